// File: rtl/rgb2luma_stream_if.sv
// rtl/rgb2luma_stream_if.sv - component-in / luma-out handshake bundle
interface rgb2luma_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/rgb2luma_stream.sv
// rtl/rgb2luma_stream.sv - three-beat RGB/BGR component stream to rounded, saturated luma
module rgb2luma_stream #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 10,
  parameter int COEF_R = 306,
  parameter int COEF_G = 601,
  parameter int COEF_B = 117
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             order_bgr,
  rgb2luma_stream_if.slave bus,
  output logic [1:0]       phase
);
  localparam int ACC_W = DATA_W + FRAC_W + 2;
  localparam int SUM_W = ACC_W + 1;
  localparam int Y_W   = SUM_W - FRAC_W;

  localparam logic [ACC_W-1:0]  CR    = ACC_W'(COEF_R);
  localparam logic [ACC_W-1:0]  CG    = ACC_W'(COEF_G);
  localparam logic [ACC_W-1:0]  CB    = ACC_W'(COEF_B);
  localparam logic [SUM_W-1:0]  RND   = SUM_W'(2 ** (FRAC_W - 1));
  localparam logic [Y_W-1:0]    Y_MAX = Y_W'(2 ** DATA_W - 1);

  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2
  } phase_t;

  phase_t             phase_q, phase_d;
  logic               order_q, order_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;

  logic               accept;
  logic               load;
  logic               cur_order;
  logic [ACC_W-1:0]   coef;
  logic [ACC_W-1:0]   prod;
  logic [SUM_W-1:0]   sum_rnd;
  logic [Y_W-1:0]     y_full;
  logic [DATA_W-1:0]  y_sat;

  // Only the completing beat can stall, and only against a stuck result.
  assign bus.in_ready = rst_n && !clear &&
                        !(phase_q == PH_2 && out_valid_q && !bus.out_ready);
  assign accept    = bus.in_valid && bus.in_ready;
  assign load      = accept && (phase_q == PH_2);
  assign cur_order = (phase_q == PH_0) ? order_bgr : order_q;

  always_comb begin
    coef = CG;
    if (phase_q == PH_0) begin
      coef = cur_order ? CB : CR;
    end else if (phase_q == PH_2) begin
      coef = cur_order ? CR : CB;
    end
  end

  assign prod    = ACC_W'(bus.in_data) * coef;
  assign sum_rnd = SUM_W'(acc_q) + SUM_W'(prod) + RND;
  assign y_full  = sum_rnd[SUM_W-1:FRAC_W];
  assign y_sat   = (y_full > Y_MAX) ? {DATA_W{1'b1}} : y_full[DATA_W-1:0];

  always_comb begin
    phase_d     = phase_q;
    acc_d       = acc_q;
    order_d     = order_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      phase_d = PH_0;
      acc_d   = '0;
    end else if (accept) begin
      case (phase_q)
        PH_0: begin
          phase_d = PH_1;
          acc_d   = prod;
          order_d = order_bgr;
        end
        PH_1: begin
          phase_d = PH_2;
          acc_d   = acc_q + prod;
        end
        default: begin
          phase_d = PH_0;
        end
      endcase
    end

    // A load wins over a simultaneous consume so back-to-back pixels have no bubble.
    if (load) begin
      out_data_d  = y_sat;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_0;
      acc_q       <= '0;
      order_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      order_q     <= order_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign phase         = phase_q;
endmodule

// File: tb/tb_rgb2luma_stream.sv
// tb/tb_rgb2luma_stream.sv - randomized and directed checks of rgb2luma_stream against a luma model
module tb_rgb2luma_stream;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       order_bgr = 1'b0;
  logic [1:0] phase;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int gap_max = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  bit rnd_done = 1'b0;

  rgb2luma_stream_if #(.DATA_W(8)) bus ();

  rgb2luma_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .order_bgr (order_bgr),
    .bus       (bus),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int luma(input int r, input int g, input int b);
    int y;
    y = (r * 306 + g * 601 + b * 117 + 512) / 1024;
    return (y > 255) ? 255 : y;
  endfunction

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input int v);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'(v);
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("beat_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_pixel(input int a, input int b, input int c, input bit ord, input bit expect_out);
    if (expect_out) exp_q.push_back(ord ? luma(c, b, a) : luma(a, b, c));
    order_bgr = ord;
    send_beat(a);
    order_bgr = 1'($urandom);
    idle_cycles($urandom_range(0, gap_max));
    send_beat(b);
    order_bgr = 1'($urandom);
    idle_cycles($urandom_range(0, gap_max));
    send_beat(c);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("hold", {bus.out_valid, bus.out_data}, {1'b1, prev_data});
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("luma", bus.out_data, exp_q.pop_front());
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_phase", phase, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    bus.out_ready = 1'b1;
    send_pixel(255, 255, 255, 1'b0, 1'b1);
    @(negedge clk);
    check("pulse_valid", bus.out_valid, 1);
    check("pulse_phase", phase, 0);
    @(negedge clk);
    check("pulse_end", bus.out_valid, 0);
    @(posedge clk);
    #1;

    send_pixel(10, 20, 30, 1'b0, 1'b1);
    send_pixel(30, 20, 10, 1'b1, 1'b1);
    send_pixel(100, 0, 0, 1'b0, 1'b1);
    send_pixel(0, 100, 0, 1'b0, 1'b1);
    send_pixel(0, 0, 200, 1'b0, 1'b1);
    idle_cycles(3);
    check("q_empty_dir", exp_q.size(), 0);

    // Backpressure: second pixel's final beat must wait for the first result.
    bus.out_ready = 1'b0;
    send_pixel(10, 20, 30, 1'b0, 1'b1);
    exp_q.push_back(luma(100, 0, 0));
    order_bgr = 1'b0;
    send_beat(100);
    send_beat(0);
    check("stall_phase", phase, 2);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", bus.in_ready, 0);
      check("stall_data", bus.out_data, luma(10, 20, 30));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("second_valid", bus.out_valid, 1);
    check("second_data", bus.out_data, luma(100, 0, 0));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    idle_cycles(3);
    check("q_empty_bp", exp_q.size(), 0);

    // Clear drops the partial 50,60 pixel.
    order_bgr = 1'b0;
    send_beat(50);
    send_beat(60);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    @(negedge clk);
    check("clear_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("clear_phase", phase, 0);
    @(posedge clk);
    #1;
    send_pixel(10, 20, 30, 1'b0, 1'b1);
    idle_cycles(4);
    check("q_empty_clear", exp_q.size(), 0);

    // Asynchronous reset with a partial pixel and a pending output.
    bus.out_ready = 1'b0;
    send_pixel(10, 20, 30, 1'b0, 1'b0);
    send_beat(40);
    send_beat(50);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_phase", phase, 0);
    check("arst_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send_pixel(100, 0, 0, 1'b0, 1'b1);
    idle_cycles(3);
    check("q_empty_rst", exp_q.size(), 0);

    // Randomized traffic with gaps, mid-pixel order flips and random backpressure.
    gap_max = 2;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          send_pixel($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), 1'($urandom), 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    idle_cycles(10);
    check("q_empty_rnd", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
